// File: rtl/trainer_exec.sv
// Single-step instruction executor: debounced button latches a DIP instruction, runs it on a 4x8 register file.
// Optional TRAINER_EXEC_TRAP_EN: reserved opcodes trap (error=1, led=0xEE) until reset.
module trainer_exec #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] trainer_dip,
    input  logic       activate_button,
    output logic [7:0] led,
    output logic       busy,
    output logic       carry,
    output logic       error
);

    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_DEC = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2, stable, stable_q;
    logic [CNT_W-1:0] db_cnt;
    logic             press;
    logic [7:0]       ir, ir_nxt;
    logic [7:0]       regs [4];
    logic [7:0]       rd_val, rs_val;
    logic [8:0]       sum9;
    logic             wr_en;
    logic [7:0]       wr_val;
    logic [7:0]       led_nxt;
    logic             carry_nxt, error_nxt, busy_nxt;

    // Synchronizer and debouncer: level must persist DEBOUNCE_CYCLES before acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= activate_button;
            sync2    <= sync1;
            stable_q <= stable;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LIMIT) begin
                stable <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign press  = stable & ~stable_q;
    assign rd_val = regs[ir[3:2]];
    assign rs_val = regs[ir[1:0]];

    // State, instruction, register file and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= 8'h00;
            led   <= 8'h00;
            busy  <= 1'b0;
            carry <= 1'b0;
            error <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'(i);
            end
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
            led   <= led_nxt;
            busy  <= busy_nxt;
            carry <= carry_nxt;
            error <= error_nxt;
            if (wr_en) begin
                regs[ir[3:2]] <= wr_val;
            end
        end
    end

    // Next-state and execute logic; rd == rs reads the pre-write value.
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        led_nxt   = led;
        carry_nxt = carry;
        error_nxt = error;
        wr_en     = 1'b0;
        wr_val    = rd_val;
        sum9      = 9'd0;
        case (state)
            IDLE: begin
                if (press) begin
                    ir_nxt    = trainer_dip;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = HOLD;
                led_nxt   = rd_val;
                case (ir[7:4])
                    OP_NOP: ;
                    OP_ADD: begin
                        sum9      = {1'b0, rd_val} + {1'b0, rs_val};
                        wr_en     = 1'b1;
                        wr_val    = sum9[7:0];
                        carry_nxt = sum9[8];
                    end
                    OP_SUB: begin
                        sum9      = {1'b0, rd_val} - {1'b0, rs_val};
                        wr_en     = 1'b1;
                        wr_val    = sum9[7:0];
                        carry_nxt = sum9[8];
                    end
                    OP_AND: begin
                        wr_en     = 1'b1;
                        wr_val    = rd_val & rs_val;
                        carry_nxt = 1'b0;
                    end
                    OP_OR: begin
                        wr_en     = 1'b1;
                        wr_val    = rd_val | rs_val;
                        carry_nxt = 1'b0;
                    end
                    OP_XOR: begin
                        wr_en     = 1'b1;
                        wr_val    = rd_val ^ rs_val;
                        carry_nxt = 1'b0;
                    end
                    OP_MOV: begin
                        wr_en  = 1'b1;
                        wr_val = rs_val;
                    end
                    OP_INC: begin
                        sum9      = {1'b0, rd_val} + 9'd1;
                        wr_en     = 1'b1;
                        wr_val    = sum9[7:0];
                        carry_nxt = sum9[8];
                    end
                    OP_DEC: begin
                        sum9      = {1'b0, rd_val} - 9'd1;
                        wr_en     = 1'b1;
                        wr_val    = sum9[7:0];
                        carry_nxt = sum9[8];
                    end
                    OP_SHL: begin
                        wr_en     = 1'b1;
                        wr_val    = {rd_val[6:0], 1'b0};
                        carry_nxt = rd_val[7];
                    end
                    OP_SHR: begin
                        wr_en     = 1'b1;
                        wr_val    = {1'b0, rd_val[7:1]};
                        carry_nxt = rd_val[0];
                    end
                    default: begin
`ifdef TRAINER_EXEC_TRAP_EN
                        error_nxt = 1'b1;
                        led_nxt   = 8'hEE;
`endif
                    end
                endcase
                if (wr_en) begin
                    led_nxt = wr_val;
                end
            end
            HOLD: begin
                // A trapped executor parks here until reset.
                if (!stable && !error) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_trainer_exec.sv
// Bench for trainer_exec: press-level behavioural model checked every cycle, plus literal result checks.
module tb_trainer_exec;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] trainer_dip;
    logic       activate_button;
    logic [7:0] led;
    logic       busy;
    logic       carry;
    logic       error;

    trainer_exec #(.DEBOUNCE_CYCLES(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .trainer_dip     (trainer_dip),
        .activate_button (activate_button),
        .led             (led),
        .busy            (busy),
        .carry           (carry),
        .error           (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    // Model state: architectural registers and expected outputs.
    int         m_r [4];
    logic [7:0] exp_led;
    logic       exp_busy, exp_carry, exp_error, trapped;
    int         t_rise = -1, t_exec = -1, t_fall = -1;
    logic [7:0] p_dip;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_exec(input logic [7:0] instr);
        int op, rd, rs, a, b, s, res;
        bit wr;
        op = int'(instr[7:4]);
        rd = int'(instr[3:2]);
        rs = int'(instr[1:0]);
        a = m_r[rd];
        b = m_r[rs];
        wr = 1'b1;
        res = a;
        case (op)
            1: begin s = a + b; res = s % 256; exp_carry = (s > 255); end
            2: begin res = (a - b + 256) % 256; exp_carry = (a < b); end
            3: begin res = a & b; exp_carry = 1'b0; end
            4: begin res = a | b; exp_carry = 1'b0; end
            5: begin res = a ^ b; exp_carry = 1'b0; end
            6: res = b;
            7: begin s = a + 1; res = s % 256; exp_carry = (s > 255); end
            8: begin res = (a + 255) % 256; exp_carry = (a == 0); end
            9: begin res = (a * 2) % 256; exp_carry = (a >= 128); end
            10: begin res = a / 2; exp_carry = (a % 2 == 1); end
            default: wr = 1'b0;
        endcase
        if (wr) m_r[rd] = res;
        exp_led = 8'(m_r[rd]);
`ifdef TRAINER_EXEC_TRAP_EN
        if (op >= 11) begin
            exp_error = 1'b1;
            exp_led = 8'hEE;
            trapped = 1'b1;
        end
`endif
    endtask

    // Model advance: press-level events scheduled by the driver, applied at their edges.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_r = '{0, 1, 2, 3};
            exp_led = 8'h00;
            exp_busy = 1'b0;
            exp_carry = 1'b0;
            exp_error = 1'b0;
            trapped = 1'b0;
            t_rise = -1;
            t_exec = -1;
            t_fall = -1;
        end else if (!trapped) begin
            if (cyc == t_rise) exp_busy = 1'b1;
            if (cyc == t_exec) model_exec(p_dip);
            if (cyc == t_fall) exp_busy = 1'b0;
        end
    end

    // Every-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("led", led, exp_led);
            chk("busy", 8'(busy), 8'(exp_busy));
            chk("carry", 8'(carry), 8'(exp_carry));
            chk("error", 8'(error), 8'(exp_error));
        end
    end

    // Clean press sampled at next edge k; busy rises k+D+3, exec k+D+4, busy falls release+D+3.
    task automatic press(input logic [7:0] dip, input logic [7:0] dip_late, input int hold);
        @(negedge clk);
        trainer_dip = dip;
        p_dip = dip;
        activate_button = 1'b1;
        t_rise = cyc + D + 4;
        t_exec = cyc + D + 5;
        for (int n = 1; n <= hold; n++) begin
            @(negedge clk);
            if (n == 25) trainer_dip = dip_late;
        end
        activate_button = 1'b0;
        t_fall = cyc + D + 4;
        repeat (D + 10) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        trainer_dip = 8'h00;
        activate_button = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (100) @(negedge clk);
        chk("lit_reset_led", led, 8'h00);

        // ADD R3 <- R3 + R2, held well beyond debounce
        press(8'h1E, 8'h1E, 40);
        chk("lit_add_led", led, 8'h05);
        chk("lit_add_busy", 8'(busy), 8'h00);

        // Short pulse then bounce: no press
        @(negedge clk);
        activate_button = 1'b1;
        repeat (D - 1) @(negedge clk);
        activate_button = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            activate_button = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        activate_button = 1'b0;
        repeat (40) @(negedge clk);
        chk("lit_bounce_led", led, 8'h05);

        // DEC R0 then INC R0 across the wrap
        press(8'h80, 8'h80, 40);
        chk("lit_dec_led", led, 8'hFF);
        chk("lit_dec_carry", 8'(carry), 8'h01);
        press(8'h70, 8'h70, 40);
        chk("lit_inc_led", led, 8'h00);
        chk("lit_inc_carry", 8'(carry), 8'h01);

        // DIP changes during HOLD are ignored; next press picks up the new word
        do_reset(2);
        press(8'h1E, 8'h6C, 40);
        chk("lit_hold_led", led, 8'h05);
        press(8'h6C, 8'h6C, 40);
        chk("lit_mov_led", led, 8'h00);

        // Reserved opcode, followed by another press
        press(8'hB0, 8'hB0, 40);
`ifdef TRAINER_EXEC_TRAP_EN
        chk("lit_trap_led", led, 8'hEE);
        chk("lit_trap_error", 8'(error), 8'h01);
        chk("lit_trap_busy", 8'(busy), 8'h01);
`else
        chk("lit_rsvd_led", led, 8'h00);
        chk("lit_rsvd_error", 8'(error), 8'h00);
`endif
        press(8'h1E, 8'h1E, 40);
`ifdef TRAINER_EXEC_TRAP_EN
        chk("lit_trap_ignore_led", led, 8'hEE);
`else
        chk("lit_after_rsvd_led", led, 8'h02);
`endif
        do_reset(2);
        @(negedge clk);
        chk("lit_rst_error", 8'(error), 8'h00);

        // Reset while the button is held: one fresh press afterwards
        @(negedge clk);
        trainer_dip = 8'h15;
        p_dip = 8'h15;
        activate_button = 1'b1;
        t_rise = cyc + D + 4;
        t_exec = cyc + D + 5;
        repeat (30) @(negedge clk);
        chk("lit_pre_rst_led", led, 8'h02);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t_rise = cyc + D + 4;
        t_exec = cyc + D + 5;
        @(negedge clk);
        chk("lit_in_rst_led", led, 8'h00);
        repeat (30) @(negedge clk);
        activate_button = 1'b0;
        t_fall = cyc + D + 4;
        repeat (D + 10) @(negedge clk);
        chk("lit_post_rst_led", led, 8'h02);
        chk("lit_post_rst_busy", 8'(busy), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
